keypad_lock_controller: RTL and testbench
=========================================

// Module: keypad_lock_controller
// PURPOSE
//   Command-issuing end of the door lock interface: turns keypad strobes into the
//   lock/unlock pulses consumed by doorLock and watches its doorLocked feedback.
//   Collects a PIN, compares it with a parameterised passcode, opens the lock on a
//   match, and locks out the keypad after repeated failures.
// PARAMETERS
//   CODE_DIGITS     4        PIN length in digits (1..8)
//   PASSCODE        'h1234   PIN, one BCD digit per nibble, first digit in the MS nibble
//   MAX_FAILS       3        consecutive failed entries before lockout (>=1)
//   LOCKOUT_CYCLES  1000     clk cycles the keypad stays disabled after lockout
//   RELOCK_CYCLES   500      clk cycles in OPEN before auto-relock (AUTO_RELOCK_EN only)
// PORTS
//   clk          in   1   single system clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   key_valid    in   1   one-cycle strobe: key_code is valid this cycle
//   key_code     in   4   0-9 digit, 'hA clear(*), 'hB enter(#), 'hC lock-now; others ignored
//   door_locked  in   1   doorLocked feedback from doorLock
//   lock         out  1   one-cycle lock command pulse
//   unlock       out  1   one-cycle unlock command pulse
//   lockout      out  1   high for the whole LOCKOUT state
//   fail_cnt     out  3   consecutive failed entries so far
// BEHAVIOUR
//   Reset: state IDLE; lock=0, unlock=0, lockout=0, fail_cnt=0, digit buffer/count=0.
//   All outputs registered; lock/unlock never high in the same cycle.
//   States: IDLE, ENTRY, OPEN, LOCKOUT.
//   IDLE: digit key -> store digit, count=1, go ENTRY. '#' with no digits -> failure.
//     '*' ignored. 'hC -> lock pulse next cycle, stay IDLE.
//   ENTRY: digit -> shift into buffer, count saturates at CODE_DIGITS+1 (overflow flag).
//     '*' -> clear buffer/count, IDLE. 'hC -> clear buffer, lock pulse, IDLE.
//     '#' -> compare: match iff count==CODE_DIGITS and buffer==PASSCODE.
//       match: unlock=1 in the cycle after the '#' strobe, fail_cnt=0, go OPEN.
//       mismatch: fail_cnt+1; if it reaches MAX_FAILS -> LOCKOUT, else IDLE. Buffer cleared.
//   OPEN: 'hC -> lock pulse next cycle, IDLE. door_locked rising (external relock) -> IDLE,
//     no pulse. Digits/'*'/'#' ignored.
//   LOCKOUT: lockout=1, all keys ignored, counter runs LOCKOUT_CYCLES cycles, then
//     lockout=0, fail_cnt=0, IDLE. 'hC ignored here (door already locked).
//   key_valid=0: no state change except timers. Unknown key codes: no effect anywhere.
//   Timers count from 0; exit on count==N-1 (exactly N cycles in state).
//   rst mid-operation: abort immediately to reset values; no pulse emitted in that cycle.
// CONFIGURATION
//   AUTO_RELOCK_EN defined: in OPEN a counter runs; after RELOCK_CYCLES cycles without
//     leaving, emit one lock pulse and go IDLE. Counter restarts on each OPEN entry.
//   AUTO_RELOCK_EN undefined: OPEN held until 'hC or door_locked rises; no timer logic.
// TESTING
//   rst, keys 1,2,3,4,# -> unlock=1 for exactly 1 cycle, cycle after '#'; fail_cnt=0.
//   keys 9,9,9,9,# three times -> fail_cnt 1,2 then lockout=1; 1,2,3,4,# during
//     lockout -> no unlock; lockout drops after 1000 cycles, fail_cnt=0.
//   keys 1,2,*,1,2,3,4,# -> unlock pulse; 1,2,3,4,5,# -> failure (overflow), fail_cnt=1.
//   In OPEN with AUTO_RELOCK_EN: no key for 500 cycles -> single lock pulse, IDLE;
//     without macro: no pulse after 2000 cycles; 'hC -> lock pulse.
//   Keys 1,2 then rst for 1 cycle, then 3,4,# -> failure, no unlock; outputs 0 during rst.
//   'hC in IDLE and ENTRY -> lock pulse 1 cycle; 'hC in LOCKOUT -> no pulse.

Source files
------------

// File: rtl/keypad_lock_controller.sv
// Keypad front end for doorLock: collects a PIN, issues lock/unlock pulses, locks out after repeated failures.
// Optional feature: define AUTO_RELOCK_EN to relock automatically after RELOCK_CYCLES in OPEN.
module keypad_lock_controller #(
    parameter int                       CODE_DIGITS    = 4,
    parameter logic [4*CODE_DIGITS-1:0] PASSCODE       = 'h1234,
    parameter int                       MAX_FAILS      = 3,
    parameter int                       LOCKOUT_CYCLES = 1000,
    parameter int                       RELOCK_CYCLES  = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       door_locked,
    output logic       lock,
    output logic       unlock,
    output logic       lockout,
    output logic [2:0] fail_cnt
);

    localparam int BW = 4 * CODE_DIGITS;
`ifdef AUTO_RELOCK_EN
    localparam int TMR_N = (LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES : RELOCK_CYCLES;
`else
    localparam int TMR_N = LOCKOUT_CYCLES;
`endif
    localparam int TW = (TMR_N > 1) ? $clog2(TMR_N) : 1;

    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
`ifdef AUTO_RELOCK_EN
    localparam logic [TW-1:0] RELOCK_LAST  = TW'(RELOCK_CYCLES - 1);
`endif
    localparam logic [3:0]    CNT_FULL     = 4'(CODE_DIGITS);
    localparam logic [3:0]    CNT_OVF      = 4'(CODE_DIGITS + 1);
    localparam logic [2:0]    FAIL_MAX     = 3'(MAX_FAILS);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        OPEN,
        LOCKOUT
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [2:0]      fail_q, fail_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            lock_q, lock_d;
    logic            unlock_q, unlock_d;
    logic            lockout_q;
    logic            door_q;

    logic            is_digit, is_clear, is_enter, is_lock;
    logic            door_rise;
    logic [2:0]      fail_inc;
    state_t          fail_state;

    assign is_digit   = key_valid && (key_code <= 4'd9);
    assign is_clear   = key_valid && (key_code == 4'hA);
    assign is_enter   = key_valid && (key_code == 4'hB);
    assign is_lock    = key_valid && (key_code == 4'hC);
    assign door_rise  = door_locked && !door_q;
    assign fail_inc   = fail_q + 3'd1;
    assign fail_state = (fail_inc >= FAIL_MAX) ? LOCKOUT : IDLE;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        timer_d  = '0;
        lock_d   = 1'b0;
        unlock_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_digit) begin
                    buf_d   = BW'(key_code);
                    cnt_d   = 4'd1;
                    state_d = ENTRY;
                end else if (is_enter) begin
                    fail_d  = fail_inc;
                    state_d = fail_state;
                end else if (is_lock) begin
                    lock_d  = 1'b1;
                end
            end
            ENTRY: begin
                if (is_digit) begin
                    buf_d = (buf_q << 4) | BW'(key_code);
                    cnt_d = (cnt_q == CNT_OVF) ? cnt_q : cnt_q + 4'd1;
                end else if (is_clear || is_lock || is_enter) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                    lock_d  = is_lock;
                    // A count past CODE_DIGITS never matches, even if the low digits do.
                    if (is_enter && cnt_q == CNT_FULL && buf_q == PASSCODE) begin
                        unlock_d = 1'b1;
                        fail_d   = '0;
                        state_d  = OPEN;
                    end else if (is_enter) begin
                        fail_d   = fail_inc;
                        state_d  = fail_state;
                    end
                end
            end
            OPEN: begin
                if (is_lock) begin
                    lock_d  = 1'b1;
                    state_d = IDLE;
                end else if (door_rise) begin
                    state_d = IDLE;
`ifdef AUTO_RELOCK_EN
                end else if (timer_q == RELOCK_LAST) begin
                    lock_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
`endif
                end
            end
            LOCKOUT: begin
                if (timer_q == LOCKOUT_LAST) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            fail_q    <= '0;
            timer_q   <= '0;
            lock_q    <= 1'b0;
            unlock_q  <= 1'b0;
            lockout_q <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            timer_q   <= timer_d;
            lock_q    <= lock_d;
            unlock_q  <= unlock_d;
            lockout_q <= (state_d == LOCKOUT);
            door_q    <= door_locked;
        end
    end

    assign lock     = lock_q;
    assign unlock   = unlock_q;
    assign lockout  = lockout_q;
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_keypad_lock_controller.sv
// Directed self-checking bench for keypad_lock_controller with default parameters.
module tb_keypad_lock_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       door_locked = 1'b1;
    logic       lock, unlock, lockout;
    logic [2:0] fail_cnt;

    int total = 0;
    int bad   = 0;
    int lock_cnt = 0, unlock_cnt = 0, lo_cycles = 0;
    logic both_seen = 1'b0;

    keypad_lock_controller dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .door_locked(door_locked),
        .lock       (lock),
        .unlock     (unlock),
        .lockout    (lockout),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lock)            lock_cnt++;
        if (unlock)          unlock_cnt++;
        if (lockout)         lo_cycles++;
        if (lock && unlock)  both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the key's response visible.
    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic enter_pin(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d); press(4'hB);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int l0, u0, lo0, n;

    initial begin
        @(negedge clk);
        idle(2);
        check("rst_lock",    lock,     0);
        check("rst_unlock",  unlock,   0);
        check("rst_lockout", lockout,  0);
        check("rst_fail",    fail_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Correct PIN: one-cycle unlock pulse right after '#'.
        enter_pin(1, 2, 3, 4);
        check("pin_unlock", unlock, 1);
        check("pin_fail",   fail_cnt, 0);
        @(negedge clk);
        check("pin_unlock_end", unlock, 0);
        door_locked = 1'b0;

        // Keys in OPEN are ignored.
        u0 = unlock_cnt;
        enter_pin(1, 2, 3, 4);
        idle(1);
        check("open_ignores_keys", unlock_cnt - u0, 0);

        l0 = lock_cnt;
`ifdef AUTO_RELOCK_EN
        idle(600);
        check("auto_relock_pulses", lock_cnt - l0, 1);
`else
        idle(2000);
        check("no_auto_relock", lock_cnt - l0, 0);
`endif
        press(4'hC);
        check("lock_key_pulse", lock, 1);
        @(negedge clk);
        check("lock_key_end", lock, 0);
        door_locked = 1'b1;

        // External relock via door_locked rising returns to IDLE silently.
        enter_pin(1, 2, 3, 4);
        check("relock_unlock", unlock, 1);
        door_locked = 1'b0;
        idle(2);
        l0 = lock_cnt;
        door_locked = 1'b1;
        idle(2);
        check("ext_relock_no_pulse", lock_cnt - l0, 0);
        enter_pin(1, 2, 3, 4);
        check("after_ext_relock_unlock", unlock, 1);
        press(4'hC);
        check("close1", lock, 1);

        // Clear mid-entry, then a correct PIN.
        press(1); press(2); press(4'hA);
        enter_pin(1, 2, 3, 4);
        check("clear_then_pin", unlock, 1);
        press(4'hC);

        // Five digits overflow the count and fail.
        press(1);
        enter_pin(2, 3, 4, 5);
        check("overflow_unlock", unlock, 0);
        check("overflow_fail",   fail_cnt, 1);

        // Reset mid-entry discards the buffered digits.
        press(1); press(2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {lock, unlock, lockout, fail_cnt}, 0);
        rst = 1'b0;
        press(3); press(4); press(4'hB);
        check("midrst_unlock", unlock, 0);
        check("midrst_fail",   fail_cnt, 1);

        // Unknown key codes have no effect.
        press(4'hF);
        press(1); press(2); press(4'hE);
        enter_pin(4'hD, 3, 4, 4'hF);
        check("unknown_keys_unlock", unlock, 1);
        check("unknown_keys_fail",   fail_cnt, 0);
        press(4'hC);

        // '#' with no digits counts as a failure.
        press(4'hB);
        check("empty_enter_fail", fail_cnt, 1);

        // Lock key in ENTRY pulses lock and discards the digit.
        press(7);
        press(4'hC);
        check("entry_lock_pulse", lock, 1);
        @(negedge clk);
        check("entry_lock_end", lock, 0);
        enter_pin(1, 2, 3, 4);
        check("after_entry_lock_unlock", unlock, 1);
        press(4'hC);

        // Three failures lock the keypad out for exactly LOCKOUT_CYCLES cycles.
        lo0 = lo_cycles;
        enter_pin(9, 9, 9, 9);
        check("fail1_cnt", fail_cnt, 1);
        check("fail1_lockout", lockout, 0);
        enter_pin(9, 9, 9, 9);
        check("fail2_cnt", fail_cnt, 2);
        enter_pin(9, 9, 9, 9);
        check("fail3_lockout", lockout, 1);
        check("fail3_cnt", fail_cnt, 3);
        u0 = unlock_cnt;
        l0 = lock_cnt;
        enter_pin(1, 2, 3, 4);
        press(4'hC);
        idle(1);
        check("lockout_no_unlock", unlock_cnt - u0, 0);
        check("lockout_no_lock",   lock_cnt - l0, 0);
        n = 0;
        while (lockout && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("lockout_timeout", lockout, 0);
        #1;
        check("lockout_length", lo_cycles - lo0, 1000);
        check("lockout_fail_cleared", fail_cnt, 0);
        @(negedge clk);
        enter_pin(1, 2, 3, 4);
        check("post_lockout_unlock", unlock, 1);
        press(4'hC);

        check("never_lock_and_unlock", both_seen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
